sha_computational_block: RTL and testbench
==========================================

# sha_computational_block

Single-block SHA-256 engine for the miner datapath. Accepts a message of up to 447 bits with its bit length, applies standard SHA-256 padding into one 512-bit block, runs the 64 compression rounds one per clock, and presents the 256-bit digest with a completion flag. Sits between the message/nonce formatter and the hash-comparison logic.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-high. This is the codebase name; polarity and synchronicity are fixed as stated.
- `inputMsg`  in  447  message bits, right-aligned. Message occupies `inputMsg[L-1:0]`, MSB first.
- `inputLength`  in  64  message length L in bits.
- `newMsg`  in  1  latch `inputMsg`/`inputLength` on this edge.
- `beginComputation`  in  1  start hashing the latched message.
- `computationComplete`  out  1  digest valid, held until next start or reset.
- `SHAoutput`  out  256  digest H0..H7, H0 in bits [255:224].

## Operation
- Padded block: `{inputMsg[L-1:0], 1'b1, zeros, L[63:0]}`, 512 bits total.
- L > 447 is clamped to 447 for both block formation and the length field. L = 0 is legal.
- `newMsg` high: capture message and length into internal registers.
- If `newMsg` and `beginComputation` are high on the same edge, the freshly presented inputs are hashed.
- `beginComputation` without `newMsg` rehashes the previously latched message.
- FSM states:
  - IDLE/DONE → ROUND on `beginComputation`. On this transition: build W[0..15] from the block, load a..h with the standard initial H, clear the round counter t, drop `computationComplete`.
  - ROUND: one standard compression round per cycle, t = 0..63.
    - W[t] for t ≥ 16 is produced on the fly in a 16-word shift register: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
    - After t = 63 → FINAL.
  - FINAL: `SHAoutput` ← H_init + {a..h}, each word mod 2^32. Set `computationComplete` → DONE.
- `beginComputation` while in ROUND/FINAL is ignored. `newMsg` while busy updates the latch only; the running hash is unaffected.
- All additions are 32-bit modulo 2^32. Standard Σ0/Σ1/σ0/σ1, Ch and Maj functions per FIPS 180-4.

## Timing
- Reset (async, while `n_rst` = 1): state IDLE, `computationComplete` = 0, `SHAoutput` = 0, latches = 0, t = 0.
- Latency: `beginComputation` sampled at edge 0.
  - Edges 1..64 perform rounds 0..63.
  - Edge 65 writes `SHAoutput` and asserts `computationComplete`.
  - Flag is visible after edge 65, i.e. 65 cycles.
- `computationComplete` falls on the edge that accepts the next start. `SHAoutput` holds the old digest until the next FINAL.
- Reset mid-computation aborts immediately to the reset values. No partial digest is output.

## Structure
- Shared package `sha256_pkg`:
  - K[0..63] round constants.
  - H_INIT[0..7].
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
  - FSM state enum.
- One sub-module `sha256_msg_schedule`: 16×32 shift register with parallel load and next-W generation. Round logic and FSM stay in the top module.

## Test plan
- Reset: assert `n_rst`, check `computationComplete` = 0 and `SHAoutput` = 0. Release, idle 3 cycles, outputs unchanged.
- "a": `inputMsg` = 97, `inputLength` = 8, `newMsg`/`beginComputation` pulsed 1 cycle.
  - `computationComplete` rises exactly 65 cycles later.
  - `SHAoutput` = ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
- "abc": `inputMsg` = 0x616263, `inputLength` = 24.
  - `SHAoutput` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty: `inputLength` = 0.
  - `SHAoutput` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Rehash: after "abc" completes, pulse `beginComputation` only with `inputMsg` = 97 on the bus.
  - Complete deasserts next cycle.
  - Same "abc" digest after 65 cycles.
- Abort: start "a", assert `n_rst` at round 30.
  - Outputs return to 0 immediately.
  - A restarted "a" after release yields the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions, FSM encoding and block padding
// used by the single-block hashing engine.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } sha_state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Lengths beyond one block's capacity are treated as the maximum.
    function automatic logic [8:0] clamp_len(input logic [63:0] len);
        logic [8:0] result;
        if (len > 64'd447) begin
            result = 9'd447;
        end else begin
            result = len[8:0];
        end
        return result;
    endfunction

    // Shifting left by (512-L) drops any message bits above L-1 off the top.
    function automatic logic [511:0] pad_block(input logic [446:0] msg, input logic [8:0] len);
        logic [511:0] body;
        logic [511:0] marker;
        body   = {65'd0, msg} << (10'd512 - {1'b0, len});
        marker = {511'd0, 1'b1} << (10'd511 - {1'b0, len});
        return body | marker | {503'd0, len};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// Sixteen-word message schedule window: parallel load of W[0..15], then one
// shift per round that appends the next expanded word.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  w_t
);

    logic [31:0] w_r [0:15];
    logic [31:0] w_next_s;

    // Expansion of W[t+16] from the current window, where w_r[0] holds W[t].
    always_comb begin
        w_next_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    end

    // Window register: load from the padded block or slide by one word.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'd0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w_r[i] <= w_r[i + 1];
            end
            w_r[15] <= w_next_s;
        end
    end

    assign w_t = w_r[0];

endmodule

// File: rtl/sha_computational_block.sv
// Single-block SHA-256 engine: pads a message of up to 447 bits, runs one
// compression round per clock and holds the digest until the next start.
module sha_computational_block
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic [446:0] inputMsg,
    input  logic [63:0]  inputLength,
    input  logic         newMsg,
    input  logic         beginComputation,
    output logic         computationComplete,
    output logic [255:0] SHAoutput
);

    sha_state_e   state_r;
    sha_state_e   next_state_s;
    logic [446:0] msg_r;
    logic [8:0]   len_r;
    logic [446:0] sel_msg_s;
    logic [8:0]   sel_len_s;
    logic [511:0] block_s;
    logic [5:0]   round_r;
    logic [31:0]  work_r [0:7];
    logic [31:0]  w_t_s;
    logic [31:0]  t1_s;
    logic [31:0]  t2_s;
    logic         load_s;
    logic         round_en_s;
    logic         final_s;

    // Message/length latch, written whenever a new message is presented.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            msg_r <= 447'd0;
            len_r <= 9'd0;
        end else if (newMsg) begin
            msg_r <= inputMsg;
            len_r <= clamp_len(inputLength);
        end
    end

    // A simultaneous newMsg/start hashes the bus, not the stale latch.
    always_comb begin
        sel_msg_s = msg_r;
        sel_len_s = len_r;
        if (newMsg) begin
            sel_msg_s = inputMsg;
            sel_len_s = clamp_len(inputLength);
        end else begin
            sel_msg_s = msg_r;
            sel_len_s = len_r;
        end
        block_s = pad_block(sel_msg_s, sel_len_s);
    end

    sha256_msg_schedule u_schedule (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (load_s),
        .shift (round_en_s),
        .block (block_s),
        .w_t   (w_t_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        round_en_s   = 1'b0;
        final_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (beginComputation) begin
                    next_state_s = ST_ROUND;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_ROUND: begin
                round_en_s = 1'b1;
                if (round_r == 6'd63) begin
                    next_state_s = ST_FINAL;
                end else begin
                    next_state_s = ST_ROUND;
                end
            end
            ST_FINAL: begin
                final_s      = 1'b1;
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Compression round temporaries, work_r[0..7] = a..h.
    always_comb begin
        t1_s = work_r[7] + big_sigma1(work_r[4]) + ch(work_r[4], work_r[5], work_r[6])
             + K[round_r] + w_t_s;
        t2_s = big_sigma0(work_r[0]) + maj(work_r[0], work_r[1], work_r[2]);
    end

    // Working variables, round counter, digest and completion flag.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < 8; i++) begin
                work_r[i] <= 32'd0;
            end
            round_r             <= 6'd0;
            computationComplete <= 1'b0;
            SHAoutput           <= 256'd0;
        end else if (load_s) begin
            for (int i = 0; i < 8; i++) begin
                work_r[i] <= H_INIT[i];
            end
            round_r             <= 6'd0;
            computationComplete <= 1'b0;
        end else if (round_en_s) begin
            work_r[0] <= t1_s + t2_s;
            work_r[1] <= work_r[0];
            work_r[2] <= work_r[1];
            work_r[3] <= work_r[2];
            work_r[4] <= work_r[3] + t1_s;
            work_r[5] <= work_r[4];
            work_r[6] <= work_r[5];
            work_r[7] <= work_r[6];
            round_r   <= round_r + 6'd1;
        end else if (final_s) begin
            for (int i = 0; i < 8; i++) begin
                SHAoutput[255 - 32*i -: 32] <= H_INIT[i] + work_r[i];
            end
            computationComplete <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha_computational_block.sv
// Bench for sha_computational_block: known digests, latency, rehash, busy
// updates, abort, and random messages against an independent SHA-256 model.
module tb_sha_computational_block;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [446:0] inputMsg;
    logic [63:0]  inputLength;
    logic         newMsg;
    logic         beginComputation;
    logic         computationComplete;
    logic [255:0] SHAoutput;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] DIG_A   = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_E   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] HT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    sha_computational_block dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .inputMsg            (inputMsg),
        .inputLength         (inputLength),
        .newMsg              (newMsg),
        .beginComputation    (beginComputation),
        .computationComplete (computationComplete),
        .SHAoutput           (SHAoutput)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 of one padded block: bitwise padding, full 64-word schedule.
    function automatic logic [255:0] sha_model(input logic [446:0] msg, input logic [63:0] len);
        logic [511:0] blk;
        logic [31:0]  w [0:63];
        logic [31:0]  v [0:7];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [63:0]  lc;
        int           l;
        lc  = (len > 64'd447) ? 64'd447 : len;
        l   = int'(lc);
        blk = '0;
        for (int i = 0; i < l; i++) blk[511 - i] = msg[l - 1 - i];
        blk[511 - l] = 1'b1;
        blk[63:0]    = lc;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = HT[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        return {HT[0] + v[0], HT[1] + v[1], HT[2] + v[2], HT[3] + v[3],
                HT[4] + v[4], HT[5] + v[5], HT[6] + v[6], HT[7] + v[7]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_dig(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a start (optionally with a new message) for one edge.
    task automatic start_hash(input string tag, input logic [446:0] msg, input logic [63:0] len,
                              input logic nm);
        inputMsg         = msg;
        inputLength      = len;
        newMsg           = nm;
        beginComputation = 1'b1;
        tick();
        newMsg           = 1'b0;
        beginComputation = 1'b0;
        check_bit({tag, "_busy_flag"}, computationComplete, 1'b0);
    endtask

    // Wait (bounded) for completion; n0 edges since the start edge have already elapsed.
    task automatic wait_done(input string tag, input int n0, input logic [255:0] exp);
        int n;
        n = n0;
        while (computationComplete !== 1'b1 && n < 120) begin
            tick();
            n++;
        end
        check_int({tag, "_latency"}, n, 65);
        check_dig({tag, "_digest"}, SHAoutput, exp);
    endtask

    task automatic rand_msg(output logic [446:0] m);
        m = '0;
        for (int i = 0; i < 14; i++) m = (m << 32) | 447'($urandom());
    endtask

    initial begin
        logic [446:0] rmsg;
        logic [63:0]  rlen;
        logic [255:0] prev;

        n_rst            = 1'b1;
        inputMsg         = '0;
        inputLength      = 64'd0;
        newMsg           = 1'b0;
        beginComputation = 1'b0;
        tick();
        tick();
        check_bit("rst_flag", computationComplete, 1'b0);
        check_dig("rst_digest", SHAoutput, 256'd0);
        n_rst = 1'b0;
        tick();
        tick();
        tick();
        check_bit("idle_flag", computationComplete, 1'b0);
        check_dig("idle_digest", SHAoutput, 256'd0);

        start_hash("a", 447'd97, 64'd8, 1'b1);
        wait_done("a", 0, DIG_A);
        tick();
        tick();
        check_bit("a_hold_flag", computationComplete, 1'b1);
        check_dig("a_hold_digest", SHAoutput, DIG_A);

        start_hash("abc", 447'h616263, 64'd24, 1'b1);
        check_dig("abc_old_digest_held", SHAoutput, DIG_A);
        wait_done("abc", 0, DIG_ABC);

        // Rehash of the latched "abc" while "a" sits on the bus without newMsg.
        start_hash("rehash", 447'd97, 64'd8, 1'b0);
        check_dig("rehash_old_digest", SHAoutput, DIG_ABC);
        wait_done("rehash", 0, DIG_ABC);

        start_hash("empty", '0, 64'd0, 1'b1);
        wait_done("empty", 0, DIG_E);

        // newMsg and an ignored start during a run only update the latch.
        start_hash("busy", 447'h616263, 64'd24, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        inputMsg         = 447'd97;
        inputLength      = 64'd8;
        newMsg           = 1'b1;
        beginComputation = 1'b1;
        tick();
        newMsg           = 1'b0;
        beginComputation = 1'b0;
        inputMsg         = '0;
        wait_done("busy", 21, DIG_ABC);
        start_hash("busy_relatch", '0, 64'd0, 1'b0);
        wait_done("busy_relatch", 0, DIG_A);

        // Abort with reset during round 30, then restart.
        start_hash("abort", 447'd97, 64'd8, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        n_rst = 1'b1;
        #1;
        check_bit("abort_flag", computationComplete, 1'b0);
        check_dig("abort_digest", SHAoutput, 256'd0);
        tick();
        n_rst = 1'b0;
        tick();
        check_bit("abort_idle_flag", computationComplete, 1'b0);
        start_hash("restart", 447'd97, 64'd8, 1'b1);
        wait_done("restart", 0, DIG_A);

        // Random messages; odd iterations latch first then start without newMsg.
        for (int it = 0; it < 8; it++) begin
            rand_msg(rmsg);
            case (it)
                0:       rlen = 64'd447;
                1:       rlen = 64'd600;
                2:       rlen = 64'd446;
                3:       rlen = {32'($urandom()), 32'($urandom())};
                default: rlen = 64'($urandom_range(0, 447));
            endcase
            prev = sha_model(rmsg, rlen);
            if (it % 2 == 0) begin
                start_hash("rand", rmsg, rlen, 1'b1);
            end else begin
                inputMsg    = rmsg;
                inputLength = rlen;
                newMsg      = 1'b1;
                tick();
                newMsg      = 1'b0;
                start_hash("rand", ~rmsg, 64'd5, 1'b0);
            end
            wait_done("rand", 0, prev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
